// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter (with per-requester lock) in front of a config/status register bank.
// Owns the config storage; one single-register read or write per granted transaction.
module reg_access_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int NUM_CFG    = 8,
   parameter int NUM_STATUS = 8,
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ena,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               we,
   input  logic [NUM_REQ-1:0]               lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
   input  logic [NUM_REQ*REG_WIDTH-1:0]     wdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               ack,
   output logic [REG_WIDTH-1:0]             rdata,
   output logic                             err,
   output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
   input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
   output logic [1:0]                       fsm_state
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IW = ADDR_WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                 state;
   logic [OW-1:0]          rr_ptr;
   logic [OW-1:0]          owner;
   logic                   lock_valid;
   logic [REG_WIDTH-1:0]   cfg_mem [NUM_CFG];

   assign fsm_state = state;

   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_mem[g];
   end

   // Request fields of the current owner.
   logic                   cur_req;
   logic                   cur_we;
   logic                   cur_lock;
   logic [ADDR_WIDTH-1:0]  cur_addr;
   logic [REG_WIDTH-1:0]   cur_wdata;

   always_comb begin
      cur_req   = 1'b0;
      cur_we    = 1'b0;
      cur_lock  = 1'b0;
      cur_addr  = '0;
      cur_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == OW'(i)) begin
            cur_req   = req[i];
            cur_we    = we[i];
            cur_lock  = lock[i];
            cur_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            cur_wdata = wdata[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   // Address decode: MSB picks the bank, the rest is the register index.
   logic                   cur_bank;
   logic [31:0]            idx_w;
   logic                   cfg_in_range;
   logic                   sts_in_range;
   logic [REG_WIDTH-1:0]   cfg_rd;
   logic [REG_WIDTH-1:0]   sts_rd;

   assign cur_bank     = cur_addr[ADDR_WIDTH-1];
   assign idx_w        = 32'(cur_addr[IW-1:0]);
   assign cfg_in_range = idx_w < 32'(NUM_CFG);
   assign sts_in_range = idx_w < 32'(NUM_STATUS);

   always_comb begin
      cfg_rd = '0;
      for (int k = 0; k < NUM_CFG; k++) begin
         if (idx_w == 32'(k)) cfg_rd = cfg_mem[k];
      end
   end

   always_comb begin
      sts_rd = '0;
      for (int k = 0; k < NUM_STATUS; k++) begin
         if (idx_w == 32'(k)) sts_rd = status_regs[k*REG_WIDTH +: REG_WIDTH];
      end
   end

   // Round-robin pick: rotate req so that rr_ptr lands on bit 0, take the first set bit.
   logic [2*NUM_REQ-1:0]   req_rot;
   logic                   rr_found;
   logic [OW-1:0]          rr_pick;
   int                     rr_idx;

   assign req_rot = {req, req} >> rr_ptr;

   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!rr_found && req_rot[k]) begin
            rr_found = 1'b1;
            rr_idx   = int'(rr_ptr) + k;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            rr_pick  = OW'(rr_idx);
         end
      end
   end

   logic [OW-1:0] owner_next;
   assign owner_next = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         lock_valid <= 1'b0;
         gnt        <= '0;
         ack        <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         for (int k = 0; k < NUM_CFG; k++) cfg_mem[k] <= '0;
      end else if (ena) begin
         case (state)
            S_IDLE: begin
               ack <= '0;
               if (lock_valid && cur_req) begin
                  gnt   <= NUM_REQ'(1) << owner;
                  state <= S_ACCESS;
               end else begin
                  // A lapsed lock falls back to round-robin in the same cycle.
                  lock_valid <= 1'b0;
                  if (rr_found) begin
                     owner <= rr_pick;
                     gnt   <= NUM_REQ'(1) << rr_pick;
                     state <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (!cur_bank && cfg_in_range) begin
                  err <= 1'b0;
                  if (cur_we) begin
                     rdata <= '0;
                     for (int k = 0; k < NUM_CFG; k++) begin
                        if (idx_w == 32'(k)) cfg_mem[k] <= cur_wdata;
                     end
                  end else begin
                     rdata <= cfg_rd;
                  end
               end else if (cur_bank && sts_in_range && !cur_we) begin
                  err   <= 1'b0;
                  rdata <= sts_rd;
               end else begin
                  err   <= 1'b1;
                  rdata <= '0;
               end
               ack   <= NUM_REQ'(1) << owner;
               state <= S_DONE;
            end
            S_DONE: begin
               ack        <= '0;
               gnt        <= '0;
               lock_valid <= cur_lock;
               if (!cur_lock) rr_ptr <= owner_next;
               state      <= S_IDLE;
            end
            default: begin
               ack   <= '0;
               gnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
